// File: rtl/axis_lane_adder.sv
// axis_lane_adder: AXI4-Stream stage that adds a per-beat addend to every
// enabled lane of tdata. It uses a two-entry output/skid buffer, so it sustains
// one beat per cycle while s_axis_tready stays registered. Beat and packet
// counters count the output handshakes.
// Optional build macro: AXIS_LANE_ADD_SATURATE_EN. When it is defined, enabled
// lanes saturate at 2^LANE_W-1. When it is undefined, lanes wrap modulo 2^LANE_W.
module axis_lane_adder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [LANE_W-1:0]   addend,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [CNT_W-1:0]    beat_count,
    output logic [CNT_W-1:0]    pkt_count
);

    localparam int unsigned NLANE  = DATA_W / LANE_W;
    localparam int unsigned KEEP_W = DATA_W / 8;

    // Elaboration-time parameter sanity
    if ((DATA_W % LANE_W) != 0) begin : g_bad_lane_w
        $error("axis_lane_adder: DATA_W (%0d) must be a multiple of LANE_W (%0d)", DATA_W, LANE_W);
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("axis_lane_adder: DATA_W (%0d) must be a multiple of 8", DATA_W);
    end

    // Output (OUT) and skid (SKID) buffer entries
    logic              out_valid_q,  out_valid_d;
    logic [DATA_W-1:0] out_data_q,   out_data_d;
    logic [KEEP_W-1:0] out_keep_q,   out_keep_d;
    logic              out_last_q,   out_last_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [KEEP_W-1:0] skid_keep_q,  skid_keep_d;
    logic              skid_last_q,  skid_last_d;
    logic              s_ready_q,    s_ready_d;
    logic [CNT_W-1:0]  beat_cnt_q,   beat_cnt_d;
    logic [CNT_W-1:0]  pkt_cnt_q,    pkt_cnt_d;

    logic [DATA_W-1:0] lane_data_c;
    logic [NLANE-1:0]  lane_en_c;
    logic              in_hs_c;
    logic              out_hs_c;
    logic              out_free_c;

    // Per-lane add on the incoming beat; the addend is bound to the beat here
    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        localparam int unsigned LO_BIT  = k * LANE_W;
        localparam int unsigned LO_BYTE = LO_BIT / 8;
        localparam int unsigned HI_BYTE = (LO_BIT + LANE_W - 1) / 8;

        logic [LANE_W-1:0] lane_in_c;
        logic [LANE_W-1:0] lane_res_c;

        assign lane_in_c    = s_axis_tdata[LO_BIT +: LANE_W];
        assign lane_en_c[k] = &s_axis_tkeep[HI_BYTE:LO_BYTE];

`ifdef AXIS_LANE_ADD_SATURATE_EN
        logic [LANE_W:0] lane_sum_c;
        assign lane_sum_c = {1'b0, lane_in_c} + {1'b0, addend};
        assign lane_res_c = lane_sum_c[LANE_W] ? {LANE_W{1'b1}} : lane_sum_c[LANE_W-1:0];
`else
        assign lane_res_c = lane_in_c + addend;
`endif

        assign lane_data_c[LO_BIT +: LANE_W] = lane_en_c[k] ? lane_res_c : lane_in_c;
    end

    assign in_hs_c    = s_axis_tvalid & s_ready_q;
    assign out_hs_c   = out_valid_q & m_axis_tready;
    assign out_free_c = ~out_valid_q | m_axis_tready;

    // Buffer steering and counter next-state
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;
        skid_last_d  = skid_last_q;
        beat_cnt_d   = beat_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;

        if (skid_valid_q) begin
            // Input is blocked while SKID is full; only a drain can happen
            if (out_hs_c) begin
                out_data_d   = skid_data_q;
                out_keep_d   = skid_keep_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_hs_c) begin
            if (out_free_c) begin
                out_valid_d = 1'b1;
                out_data_d  = lane_data_c;
                out_keep_d  = s_axis_tkeep;
                out_last_d  = s_axis_tlast;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = lane_data_c;
                skid_keep_d  = s_axis_tkeep;
                skid_last_d  = s_axis_tlast;
            end
        end else if (out_hs_c) begin
            out_valid_d = 1'b0;
        end

        if (out_hs_c) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (out_last_q) begin
                pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            end
        end

        s_ready_d = ~skid_valid_d;
    end

    // State registers, cleared asynchronously on areset
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_keep_q  <= '0;
            skid_last_q  <= 1'b0;
            s_ready_q    <= 1'b0;
            beat_cnt_q   <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_keep_q  <= skid_keep_d;
            skid_last_q  <= skid_last_d;
            s_ready_q    <= s_ready_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tlast  = out_last_q;
    assign beat_count    = beat_cnt_q;
    assign pkt_count     = pkt_cnt_q;

endmodule

// File: tb/tb_axis_lane_adder.sv
// Scoreboard bench for axis_lane_adder (DATA_W=32, LANE_W=8, CNT_W=32).
module tb_axis_lane_adder;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  addend;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] beat_count;
    logic [31:0] pkt_count;

    axis_lane_adder #(.DATA_W(32), .LANE_W(8), .CNT_W(32)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .addend        (addend),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .beat_count    (beat_count),
        .pkt_count     (pkt_count)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    checks     = 0;
    int    failures   = 0;
    int    out_beats  = 0;
    int    out_pkts   = 0;
    int    ready_mode = 0;
    int    phase      = 0;
    int    cyc        = 0;
    bit    stall_prev = 0;
    bit    armed      = 0;
    beat_t stall_hold;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each byte with its keep bit set gets the addend added
    function automatic logic [31:0] model(input logic [31:0] d, input logic [3:0] k, input logic [7:0] a);
        logic [31:0] r;
        int          s;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) begin
                s = int'(d[8*i +: 8]) + int'(a);
`ifdef AXIS_LANE_ADD_SATURATE_EN
                if (s > 255) s = 255;
`else
                s = s % 256;
`endif
                r[8*i +: 8] = 8'(s);
            end
        end
        return r;
    endfunction

    always @(posedge aclk) cyc++;

    // Output ready patterns: 0 always, 1 random, 2 one-on/two-off, 3 held low
    always @(posedge aclk) begin
        #1;
        case (ready_mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'($urandom % 2);
            2: begin m_tready = (phase == 0); phase = (phase + 1) % 3; end
            default: m_tready = 1'b0;
        endcase
    end

    // Monitor and scoreboard, sampled between active edges
    always @(negedge aclk) begin
        beat_t e;
        if (areset) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 64'(m_tvalid), 64'(1));
                check("stall_payload", 64'({m_tdata, m_tkeep, m_tlast}), 64'(stall_hold));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'({m_tdata, m_tkeep, m_tlast}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", 64'({m_tdata, m_tkeep, m_tlast}), 64'(e));
                    out_beats++;
                    if (e.last) out_pkts++;
                end
            end
            stall_prev = m_tvalid && !m_tready;
            stall_hold = {m_tdata, m_tkeep, m_tlast};
            if (armed && !s_tready) check("ready_low_only_when_full", 64'(m_tvalid), 64'(1));
            if (s_tvalid && s_tready) exp_q.push_back({model(s_tdata, s_tkeep, addend), s_tkeep, s_tlast});
        end
    end

    // Present one beat and hold it until accepted (entered and left at posedge+1)
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [7:0] a);
        int guard = 0;
        bit done  = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        addend   = a;
        s_tvalid = 1'b1;
        while (!done) begin
            @(negedge aclk);
            done = s_tready;
            guard++;
            @(posedge aclk);
            #1;
            if (!done && guard > 500) begin
                check("send_timeout", 64'(0), 64'(1));
                done = 1;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            addend = 8'($urandom);
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || m_tvalid) && guard < 2000) begin
            @(posedge aclk);
            #1;
            guard++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int          t0;
        logic [31:0] b0, p0;

        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        addend   = '0;
        m_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_s_tready", 64'(s_tready), 64'(0));
        check("rst_m_payload", 64'({m_tdata, m_tkeep, m_tlast}), 64'(0));
        check("rst_beat_count", 64'(beat_count), 64'(0));
        check("rst_pkt_count", 64'(pkt_count), 64'(0));
        areset = 1'b0;
        #1;
        check("ready_low_before_edge", 64'(s_tready), 64'(0));
        @(posedge aclk);
        #1;
        check("ready_after_release", 64'(s_tready), 64'(1));
        armed = 1;

        // 256 incrementing beats, addend 1, no backpressure
        t0 = cyc;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(4 * i);
            send({b + 8'd3, b + 8'd2, b + 8'd1, b}, 4'hF, 1'b0, 8'h01);
        end
        check("throughput_cycles", 64'(cyc - t0), 64'(256));
        drain();
        check("beat_count_256", 64'(beat_count), 64'(256));
        check("pkt_count_0", 64'(pkt_count), 64'(0));

        // Lane boundaries and partial keep
        send(32'hFF80_7F00, 4'hF, 1'b0, 8'h01);
        send(32'h1122_3344, 4'b0101, 1'b0, 8'h10);
        send(32'hFFFF_FFFF, 4'hF, 1'b1, 8'hFF);
        send(32'h0000_0000, 4'h0, 1'b0, 8'hAA);
        drain();

        // 64 random beats under a one-on/two-off slave
        ready_mode = 2;
        for (int i = 0; i < 64; i++) begin
            send($urandom, 4'($urandom), 1'($urandom), 8'($urandom));
        end
        drain();

        // 10 packets of 7 beats under random backpressure
        ready_mode = 1;
        b0 = beat_count;
        p0 = pkt_count;
        for (int p = 0; p < 10; p++) begin
            for (int j = 0; j < 7; j++) begin
                send($urandom, 4'hF, 1'(j == 6), 8'($urandom));
                if ($urandom % 4 == 0) idle(int'($urandom % 3));
            end
        end
        drain();
        check("pkt_delta_10", 64'(pkt_count - p0), 64'(10));
        check("beat_delta_70", 64'(beat_count - b0), 64'(70));

        // Random traffic with idle gaps
        for (int i = 0; i < 200; i++) begin
            send($urandom, 4'($urandom), 1'($urandom), 8'($urandom));
            if ($urandom % 3 == 0) idle(int'($urandom % 4));
        end
        drain();
        check("beat_count_total", 64'(beat_count), 64'(out_beats));
        check("pkt_count_total", 64'(pkt_count), 64'(out_pkts));

        // Fill OUT and SKID, then reset mid-flight
        ready_mode = 3;
        idle(2);
        send(32'hDEAD_BEEF, 4'hF, 1'b0, 8'h11);
        send(32'hCAFE_F00D, 4'hF, 1'b1, 8'h22);
        @(negedge aclk);
        check("full_s_tready_low", 64'(s_tready), 64'(0));
        check("full_m_tvalid_high", 64'(m_tvalid), 64'(1));
        #2;
        areset = 1'b1;
        armed  = 0;
        #1;
        check("midrst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("midrst_beat_count", 64'(beat_count), 64'(0));
        check("midrst_pkt_count", 64'(pkt_count), 64'(0));
        check("midrst_s_tready", 64'(s_tready), 64'(0));
        exp_q.delete();
        out_beats  = 0;
        out_pkts   = 0;
        ready_mode = 0;
        @(negedge aclk);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(posedge aclk);
        #1;
        check("ready_after_midrst", 64'(s_tready), 64'(1));
        armed = 1;
        send(32'h0102_0304, 4'hF, 1'b1, 8'h05);
        drain();
        idle(3);
        check("post_rst_beat_count", 64'(beat_count), 64'(1));
        check("post_rst_pkt_count", 64'(pkt_count), 64'(1));
        check("post_rst_tb_beats", 64'(out_beats), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
